// File: rtl/pin_bus_arbiter.sv
// pin_bus_arbiter: round-robin owner arbitration for the shared pin bus with
// turnaround gaps and a bounded hold time; all outputs are registered.
module pin_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 29,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1,
    localparam int IW        = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       done,
    input  logic [N_REQ*WIDTH-1:0] drv_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_oe,
    output logic [IW-1:0]          owner,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    cur, rr_ptr, pick, cur_inc;
    logic [7:0]       hold_cnt;
    logic [2:0]       turn_cnt;
    logic             rel, turn_done;
    logic [N_REQ-1:0] gnt_d;
    logic [WIDTH-1:0] bus_d;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) hit.
    always_comb begin
        pick = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[(int'(rr_ptr) + k) % N_REQ]) pick = IW'((int'(rr_ptr) + k) % N_REQ);
    end

    assign cur_inc   = (cur == IW'(N_REQ - 1)) ? '0 : cur + 1'b1;
    assign rel       = done[cur] | ~req[cur] | (hold_cnt == 8'(MAX_HOLD - 1));
    assign turn_done = turn_cnt == 3'(TURNAROUND - 1);

    always_comb begin
        state_nxt = state == IDLE  ? (|req ? GRANT : IDLE) :
                    state == GRANT ? (rel ? TURN : GRANT) :
                    state == TURN  ? (turn_done ? IDLE : TURN) : IDLE;
    end

    // Outputs are computed from the current state and registered, so they
    // trail the state register by one cycle.
    always_comb begin
        gnt_d = {N_REQ{state == GRANT}} & (N_REQ'(1) << cur);
        bus_d = (state == GRANT) ? drv_data[int'(cur)*WIDTH +: WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            bus_out  <= '0;
            bus_oe   <= 1'b0;
            busy     <= 1'b0;
            owner    <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_d;
            bus_out <= bus_d;
            bus_oe  <= state == GRANT;
            busy    <= state == GRANT;
            owner   <= cur;
            if (state == IDLE && |req) begin
                cur      <= pick;
                hold_cnt <= '0;
            end
            if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
            if (state == GRANT && rel) begin
                rr_ptr   <= cur_inc;
                turn_cnt <= '0;
            end
            if (state == TURN) turn_cnt <= turn_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pin_bus_arbiter.sv
// tb_pin_bus_arbiter: directed sequence with an expected-grant-order queue
// and per-cycle checks of grant, data steering and enable timing.
module tb_pin_bus_arbiter;
    localparam int N = 4;
    localparam int W = 29;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   done = '0;
    logic [N*W-1:0] drv_data = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   bus_out;
    logic           bus_oe, busy;
    logic [1:0]     owner;

    int pass_cnt = 0, total = 0;
    int exp_q[$];
    int cur_exp = 0, hi_len = 0, lo_len = 0, last_hi = 0, last_lo = 0;
    bit prev_oe = 1'b0, rose = 1'b0, fell = 1'b0, rnd_drv = 1'b1;

    always #5 clk = ~clk;

    pin_bus_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .drv_data(drv_data),
        .gnt(gnt), .bus_out(bus_out), .bus_oe(bus_oe), .owner(owner), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: sample outputs 1 time unit after the edge, then drive new data.
    task automatic tick();
        @(posedge clk);
        #1;
        rose = bus_oe && !prev_oe;
        fell = !bus_oe && prev_oe;
        if (rose) begin
            if (exp_q.size() == 0) chk("unexpected_grant", 64'(gnt), 64'h0);
            else cur_exp = exp_q.pop_front();
            last_lo = lo_len;
            lo_len  = 0;
        end
        if (fell) begin
            last_hi = hi_len;
            hi_len  = 0;
        end
        if (bus_oe) hi_len++; else lo_len++;
        chk("gnt", 64'(gnt), 64'(bus_oe ? (4'b1 << cur_exp) : 4'b0));
        chk("busy", 64'(busy), 64'(bus_oe));
        chk("bus_out", 64'(bus_out), 64'(bus_oe ? drv_data[cur_exp*W +: W] : '0));
        if (bus_oe) chk("owner", 64'(owner), 64'(cur_exp));
        prev_oe = bus_oe;
        if (rnd_drv)
            for (int i = 0; i < N; i++) drv_data[i*W +: W] = W'($urandom);
    endtask

    task automatic wait_rise(input string tag, input int max);
        int n = 0;
        do begin tick(); n++; end while (!rose && n < max);
        chk(tag, 64'(rose), 64'h1);
    endtask

    task automatic wait_fall(input string tag, input int max);
        int n = 0;
        do begin tick(); n++; end while (!fell && n < max);
        chk(tag, 64'(fell), 64'h1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'h0);
        chk({tag, "_oe"}, 64'(bus_oe), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_owner"}, 64'(owner), 64'h0);
        chk({tag, "_bus_out"}, 64'(bus_out), 64'h0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
    endtask

    initial begin
        // single requester: latency, data steering, release
        do_reset();
        rnd_drv = 1'b0;
        drv_data = '0;
        drv_data[1*W +: W] = 29'h0ABCDEF;
        req = 4'b0010;
        exp_q.push_back(1);
        tick();
        chk("t1_lat_early", 64'(bus_oe), 64'h0);
        tick();
        chk("t1_gnt", 64'(gnt), 64'h2);
        chk("t1_oe", 64'(bus_oe), 64'h1);
        chk("t1_bus_out", 64'(bus_out), 64'h0ABCDEF);
        done = 4'b0010;
        req  = '0;
        tick();
        done = '0;
        chk("t1_oe_lag", 64'(bus_oe), 64'h1);
        tick();
        chk("t1_release", 64'(bus_oe), 64'h0);
        repeat (4) tick();
        rnd_drv = 1'b1;

        // round-robin order with done on the 3rd grant cycle
        do_reset();
        req = 4'b1111;
        foreach (exp_q[i]) exp_q.delete(i);
        for (int k = 0; k < 5; k++) exp_q.push_back(k % N);
        for (int k = 0; k < 5; k++) begin
            wait_rise("t2_rise", 10);
            if (k > 0) chk("t2_gap", 64'(last_lo), 64'd2);
            tick();
            tick();
            done = N'(1) << cur_exp;
            if (k == 4) req = '0;
            tick();
            done = '0;
        end
        wait_fall("t2_fall", 5);
        chk("t2_len", 64'(last_hi), 64'd4);

        // timeout of a lone requester
        do_reset();
        req = 4'b0001;
        exp_q.push_back(0);
        exp_q.push_back(0);
        wait_rise("t3_rise1", 5);
        wait_fall("t3_fall", 40);
        chk("t3_hold", 64'(last_hi), 64'd16);
        wait_rise("t3_rise2", 10);
        chk("t3_gap", 64'(last_lo), 64'd2);
        req = '0;
        wait_fall("t3_end", 5);

        // timeout with a competitor waiting
        do_reset();
        req = 4'b0101;
        exp_q.push_back(0);
        exp_q.push_back(2);
        exp_q.push_back(0);
        wait_rise("t4_rise0", 5);
        wait_fall("t4_fall0", 40);
        chk("t4_hold", 64'(last_hi), 64'd16);
        wait_rise("t4_rise2", 10);
        chk("t4_gnt2", 64'(gnt), 64'h4);
        wait_fall("t4_fall2", 40);
        wait_rise("t4_rise0b", 10);
        chk("t4_gnt0", 64'(gnt), 64'h1);
        req = '0;
        wait_fall("t4_end", 5);

        // pointer wraps from 3 to 0
        do_reset();
        req = 4'b1000;
        exp_q.push_back(3);
        wait_rise("t5_rise3", 5);
        done = 4'b1000;
        req  = '0;
        tick();
        done = '0;
        wait_fall("t5_fall3", 5);
        req = 4'b1001;
        exp_q.push_back(0);
        wait_rise("t5_rise", 10);
        chk("t5_gnt", 64'(gnt), 64'h1);
        req = '0;
        wait_fall("t5_end", 5);

        // reset mid-grant clears rr_ptr (left at 2 by the first grant)
        do_reset();
        req = 4'b0010;
        exp_q.push_back(1);
        wait_rise("t6_rise1", 5);
        req = '0;
        wait_fall("t6_fall1", 5);
        req = 4'b0100;
        exp_q.push_back(2);
        wait_rise("t6_rise2", 10);
        chk("t6_gnt2", 64'(gnt), 64'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("t6_rst");
        req = 4'b0110;
        exp_q.push_back(1);
        wait_rise("t6_rise", 10);
        chk("t6_gnt", 64'(gnt), 64'h2);
        req = '0;
        wait_fall("t6_end", 5);

        chk("q_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
